// File: rtl/clause_table_loader.sv
`timescale 1ns/1ps
// clause_table_loader
// Packs a host literal stream into clause-table rows and writes each
// row once, at row addresses 0, 1, 2, ... in order.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         begin a load (sampled only while idle)
//   rows_total    number of rows to load, captured with an accepted start
//   lit_valid     literal beat offered by the host
//   lit_ready     loader takes a beat (only while filling a row)
//   lit_data      {variable address, negation} literal
//   lit_last      closes the current row early; unused slots stay zero
//   we            table write enable, one cycle per row
//   waddr         table row address (held between writes)
//   wdata         packed row, slot 0 in the LSBs (held between writes)
//   busy          high whenever a load is in progress
//   done          one-cycle pulse when the last row has been written
//   error         sticky: rows_total exceeded the table depth
module clause_table_loader #(
  parameter int CLAUSE_COUNT           = 20,
  parameter int DEPTH                  = 2048,
  parameter int VARIABLE_ADDRESS_WIDTH = 11,
  parameter int NSAT                   = 3,
  localparam int LIT_W = VARIABLE_ADDRESS_WIDTH + 1,
  localparam int SLOTS = (NSAT - 1) * CLAUSE_COUNT,
  localparam int WIDTH = LIT_W * SLOTS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [VARIABLE_ADDRESS_WIDTH:0]   rows_total,
  input  logic                              lit_valid,
  output logic                              lit_ready,
  input  logic [LIT_W-1:0]                  lit_data,
  input  logic                              lit_last,
  output logic                              we,
  output logic [VARIABLE_ADDRESS_WIDTH-1:0] waddr,
  output logic [WIDTH-1:0]                  wdata,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);

  localparam int RW     = VARIABLE_ADDRESS_WIDTH + 1;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  localparam logic [RW-1:0]     DEPTH_R   = RW'(DEPTH);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [RW-1:0]     row;
  logic [RW-1:0]     rows_q;
  logic [SLOT_W-1:0] slot;
  logic [WIDTH-1:0]  buffer;
  logic [WIDTH-1:0]  buf_next;

  // Every handshake and write strobe is decoded from state alone, so none
  // of them has a combinational path from the inputs.
  assign lit_ready = (state == S_FILL);
  assign we        = (state == S_WRITE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Row contents including the beat being accepted this cycle; this is what
  // gets registered into wdata when the beat closes the row.
  always_comb begin
    buf_next = buffer;
    buf_next[int'(slot) * LIT_W +: LIT_W] = lit_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      row    <= '0;
      rows_q <= '0;
      slot   <= '0;
      buffer <= '0;
      waddr  <= '0;
      wdata  <= '0;
      error  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (rows_total == '0) begin
              error <= 1'b0;
              state <= S_DONE;
            end else if (rows_total > DEPTH_R) begin
              error <= 1'b1;
            end else begin
              error  <= 1'b0;
              rows_q <= rows_total;
              row    <= '0;
              slot   <= '0;
              buffer <= '0;
              state  <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (lit_valid) begin
            buffer <= buf_next;
            slot   <= slot + SLOT_W'(1);
            // A last beat that also fills the final slot closes the row once.
            if (lit_last || (slot == SLOT_LAST)) begin
              wdata <= buf_next;
              waddr <= row[VARIABLE_ADDRESS_WIDTH-1:0];
              state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (row == rows_q - RW'(1)) begin
            state <= S_DONE;
          end else begin
            row    <= row + RW'(1);
            slot   <= '0;
            buffer <= '0;
            state  <= S_FILL;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clause_table_loader.sv
`timescale 1ns/1ps
module tb_clause_table_loader;

  localparam int CC   = 2;
  localparam int NS   = 3;
  localparam int VAW  = 4;
  localparam int DEP  = 8;
  localparam int LW   = VAW + 1;
  localparam int SL   = (NS - 1) * CC;
  localparam int WD   = LW * SL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [VAW:0]  rows_total = '0;
  logic          lit_valid = 1'b0;
  logic          lit_ready;
  logic [LW-1:0] lit_data = '0;
  logic          lit_last = 1'b0;
  logic          we;
  logic [VAW-1:0] waddr;
  logic [WD-1:0] wdata;
  logic          busy;
  logic          done;
  logic          error;

  clause_table_loader #(
    .CLAUSE_COUNT(CC), .DEPTH(DEP), .VARIABLE_ADDRESS_WIDTH(VAW), .NSAT(NS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rows_total(rows_total),
    .lit_valid(lit_valid), .lit_ready(lit_ready), .lit_data(lit_data),
    .lit_last(lit_last), .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [LW-1:0] bd[$];
  bit            bl[$];
  int            obs_a[$];
  logic [WD-1:0] obs_d[$];
  int            ea[$];
  logic [WD-1:0] ed[$];
  int            done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Observe writes and done pulses mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (we) begin
        obs_a.push_back(int'(waddr));
        obs_d.push_back(wdata);
        chk("ready_in_write", 32'(lit_ready), 32'd0);
      end
      if (done) done_cnt++;
    end
  end

  // Reference: pack beats into rows of SL slots, closing on lit_last or a
  // full row, and keep only the first `rows` rows.
  task automatic model(input int rows);
    int r = 0;
    int k = 0;
    logic [WD-1:0] acc = '0;
    ea.delete(); ed.delete();
    foreach (bd[i]) begin
      if (r >= rows) break;
      acc = acc | (WD'(bd[i]) << (LW * k));
      k++;
      if (bl[i] || k == SL) begin
        ea.push_back(r); ed.push_back(acc);
        acc = '0; k = 0; r++;
      end
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    chk({tag, "_nwrites"}, 32'(obs_a.size()), 32'(ea.size()));
    n = (obs_a.size() < ea.size()) ? obs_a.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_waddr"}, 32'(obs_a[i]), 32'(ea[i]));
      chk({tag, "_wdata"}, 32'(obs_d[i]), 32'(ed[i]));
    end
  endtask

  task automatic feed(input bit randv, input int start_at);
    int idx = 0;
    int cyc = 0;
    bit xfer;
    bit sent = 0;
    while (idx < bd.size() && cyc < 1000) begin
      lit_valid = randv ? ($urandom_range(0, 1) != 0) : 1'b1;
      lit_data  = bd[idx];
      lit_last  = bl[idx];
      if (start_at >= 0 && idx == start_at && !sent) begin
        start = 1'b1; rows_total = 5'd5; sent = 1;
      end
      xfer = lit_valid && lit_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (xfer) idx++;
      cyc++;
    end
    lit_valid = 1'b0; lit_last = 1'b0;
    if (idx < bd.size()) chk("feed_timeout", 32'(idx), 32'(bd.size()));
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_load(input logic [VAW:0] rows, input bit randv, input int start_at);
    obs_a.delete(); obs_d.delete(); done_cnt = 0;
    start = 1'b1; rows_total = rows;
    @(posedge clk); #1;
    start = 1'b0;
    feed(randv, start_at);
    wait_idle();
  endtask

  task automatic rand_beats(input int rows, input bit full);
    bd.delete(); bl.delete();
    for (int r = 0; r < rows; r++) begin
      int n;
      n = full ? SL : $urandom_range(1, SL);
      for (int k = 0; k < n; k++) begin
        bd.push_back(LW'($urandom));
        if (k == n - 1 && !full) bl.push_back((n < SL) ? 1'b1 : ($urandom_range(0, 1) != 0));
        else bl.push_back(1'b0);
      end
    end
  endtask

  typedef struct packed {
    logic [VAW:0]         rows;
    logic [3:0]           nb;
    logic [7:0][LW-1:0]   d;
    logic [7:0]           l;
    logic [1:0]           nexp;
    logic [1:0][WD-1:0]   ed;
    logic                 randv;
  } vec_t;

  vec_t vecs[4];

  task automatic load_vec(input vec_t v);
    bd.delete(); bl.delete();
    for (int i = 0; i < int'(v.nb); i++) begin
      bd.push_back(v.d[i]);
      bl.push_back(v.l[i]);
    end
  endtask

  initial begin
    vecs[0] = '{rows: 5'd2, nb: 4'd8,
                d: {5'h14, 5'h13, 5'h12, 5'h11, 5'h04, 5'h03, 5'h02, 5'h01},
                l: 8'h00, nexp: 2'd2, ed: {20'hA4E51, 20'h20C41}, randv: 1'b0};
    vecs[1] = '{rows: 5'd1, nb: 4'd2,
                d: {5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h06, 5'h05},
                l: 8'b0000_0010, nexp: 2'd1, ed: {20'h0, 20'h000C5}, randv: 1'b0};
    vecs[2] = vecs[0];
    vecs[2].randv = 1'b1;
    vecs[3] = '{rows: 5'd1, nb: 4'd4,
                d: {5'h0, 5'h0, 5'h0, 5'h0, 5'h04, 5'h03, 5'h02, 5'h01},
                l: 8'b0000_1000, nexp: 2'd1, ed: {20'h0, 20'h20C41}, randv: 1'b0};

    // Reset state
    #12;
    chk("rst_we", 32'(we), 0);
    chk("rst_ready", 32'(lit_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wdata", 32'(wdata), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    for (int v = 0; v < 4; v++) begin
      load_vec(vecs[v]);
      run_load(vecs[v].rows, vecs[v].randv, -1);
      chk("vec_nwrites", 32'(obs_a.size()), 32'(vecs[v].nexp));
      for (int i = 0; i < int'(vecs[v].nexp) && i < obs_a.size(); i++) begin
        chk("vec_waddr", 32'(obs_a[i]), 32'(i));
        chk("vec_wdata", 32'(obs_d[i]), 32'(vecs[v].ed[i]));
      end
      chk("vec_done", 32'(done_cnt), 1);
      chk("vec_busy_after", 32'(busy), 0);
    end

    // Bounds: too many rows
    bd.delete(); bl.delete();
    run_load(5'd9, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("over_error", 32'(error), 1);
    chk("over_busy", 32'(busy), 0);
    chk("over_nwrites", 32'(obs_a.size()), 0);
    chk("over_done", 32'(done_cnt), 0);

    // Bounds: zero rows
    run_load(5'd0, 1'b0, -1);
    chk("zero_nwrites", 32'(obs_a.size()), 0);
    chk("zero_done", 32'(done_cnt), 1);

    // Bounds: full table depth
    rand_beats(DEP, 1'b1);
    model(DEP);
    run_load(5'(DEP), 1'b1, -1);
    compare_writes("depth");
    chk("depth_error", 32'(error), 0);
    chk("depth_done", 32'(done_cnt), 1);

    // Reset mid-row: row 0 complete, two beats of row 1
    load_vec(vecs[0]);
    while (bd.size() > 6) begin
      void'(bd.pop_back());
      void'(bl.pop_back());
    end
    obs_a.delete(); obs_d.delete(); done_cnt = 0;
    start = 1'b1; rows_total = 5'd2;
    @(posedge clk); #1;
    start = 1'b0;
    feed(1'b0, -1);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(we), 0);
    chk("mid_rst_ready", 32'(lit_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_waddr", 32'(waddr), 0);
    chk("mid_rst_wdata", 32'(wdata), 0);
    chk("mid_rst_nwrites", 32'(obs_a.size()), 1);
    if (obs_a.size() > 0) chk("mid_rst_row0", 32'(obs_d[0]), 32'h20C41);
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_done", 32'(done_cnt), 0);
    load_vec(vecs[0]);
    model(2);
    run_load(5'd2, 1'b0, -1);
    compare_writes("after_rst");

    // Start while busy is ignored
    load_vec(vecs[0]);
    model(2);
    run_load(5'd2, 1'b0, 3);
    compare_writes("start_busy");
    chk("start_busy_done", 32'(done_cnt), 1);

    // Randomised loads against the reference
    for (int t = 0; t < 6; t++) begin
      int rows;
      rows = $urandom_range(1, DEP);
      rand_beats(rows, 1'b0);
      model(rows);
      run_load(5'(rows), 1'b1, -1);
      compare_writes("rand");
      chk("rand_done", 32'(done_cnt), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
